serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx_if.sv | 11 +
 rtl/serial_frame_tx.sv | 108 ++++++++++
 tb/tb_serial_frame_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Valid/ready word handshake feeding the serial frame transmitter.
interface serial_frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit (0), DATA_W data bits LSB-first, stop bit (1),
// each bit held CLKS_PER_BIT clocks on a registered, idle-high line.
module serial_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_frame_tx_if.slave  tx,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int unsigned BIT_W  = (DATA_W > 1)       ? $clog2(DATA_W)       : 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d, shift_nxt;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                accept, bit_end, last_bit;

  assign accept    = (state_q == IDLE) && tx.tx_valid;
  assign bit_end   = (baud_q == LAST_BAUD);
  assign last_bit  = (bit_q == LAST_BIT);
  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && last_bit) state_d = STOP;
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line value is computed one edge ahead so tx_out is always a flop output.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        shift_d = tx.tx_data;
        bit_d   = '0;
        baud_d  = '0;
        tx_d    = 1'b0;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) begin
        unique case (state_q)
          START: begin
            tx_d  = shift_q[0];
            bit_d = '0;
          end
          DATA: begin
            if (last_bit) begin
              tx_d = 1'b1;
            end else begin
              shift_d = shift_nxt;
              tx_d    = shift_nxt[0];
              bit_d   = bit_q + 1'b1;
            end
          end
          STOP: begin
            tx_d   = 1'b1;
            done_d = 1'b1;
          end
          default: tx_d = 1'b1;
        endcase
      end
    end
  end

  assign tx.tx_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_out      = tx_q;
  assign done        = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst_n;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  int   tests = 0;
  int   failed = 0;
  int   done_cnt_a = 0;

  serial_frame_tx_if #(.DATA_W(8)) a_if ();
  serial_frame_tx_if #(.DATA_W(8)) b_if ();

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx     (a_if),
    .tx_out (tx_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx     (b_if),
    .tx_out (tx_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 0 (just after acceptance); returns at cycle 40 (done cycle).
  // mode 0: drop valid; mode 1: churn data/valid while busy; mode 2: keep valid high.
  task automatic frame_a(input logic [7:0] w, input int mode, input string tag);
    for (int c = 0; c <= 40; c++) begin
      logic exp_bit;
      if (c < 4)       exp_bit = 1'b0;
      else if (c < 36) exp_bit = w[(c - 4) / 4];
      else             exp_bit = 1'b1;
      check({tag, " tx_out"}, 32'(tx_a), 32'(exp_bit));
      check({tag, " done"},   32'(done_a), 32'(c == 40));
      check({tag, " ready"},  32'(a_if.tx_ready), 32'(c == 40));
      check({tag, " busy"},   32'(busy_a), 32'(c != 40));
      if (mode == 1) begin
        a_if.tx_valid = (c < 40) ? (c % 2 == 1) : 1'b0;
        a_if.tx_data  = 8'h3C;
      end else if (mode == 0) begin
        a_if.tx_valid = 1'b0;
      end
      if (c < 40) @(negedge clk);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    a_if.tx_valid = 1'b0;
    a_if.tx_data  = '0;
    b_if.tx_valid = 1'b0;
    b_if.tx_data  = '0;

    // Reset held with clock running
    repeat (3) @(negedge clk);
    check("rst a tx_out", 32'(tx_a), 32'd1);
    check("rst a ready",  32'(a_if.tx_ready), 32'd1);
    check("rst a busy",   32'(busy_a), 32'd0);
    check("rst a done",   32'(done_a), 32'd0);
    check("rst b tx_out", 32'(tx_b), 32'd1);
    check("rst b ready",  32'(b_if.tx_ready), 32'd1);
    check("rst b busy",   32'(busy_b), 32'd0);
    check("rst b done",   32'(done_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame 0xA5
    a_if.tx_data  = 8'hA5;
    a_if.tx_valid = 1'b1;
    @(negedge clk);
    frame_a(8'hA5, 0, "a5");
    @(negedge clk);
    check("a5 done clear", 32'(done_a), 32'd0);
    check("a5 idle line",  32'(tx_a), 32'd1);
    check("a5 done count", 32'(done_cnt_a), 32'd1);

    // Back-to-back 0x00 then 0xFF with valid held
    a_if.tx_data  = 8'h00;
    a_if.tx_valid = 1'b1;
    @(negedge clk);
    a_if.tx_data  = 8'hFF;
    frame_a(8'h00, 2, "b2b0");
    @(negedge clk);
    frame_a(8'hFF, 0, "b2b1");
    @(negedge clk);
    check("b2b done clear", 32'(done_a), 32'd0);
    check("b2b done count", 32'(done_cnt_a), 32'd3);

    // Churn data/valid while busy with 0x81
    a_if.tx_data  = 8'h81;
    a_if.tx_valid = 1'b1;
    @(negedge clk);
    frame_a(8'h81, 1, "churn");
    repeat (3) begin
      @(negedge clk);
      check("churn idle busy", 32'(busy_a), 32'd0);
      check("churn idle line", 32'(tx_a), 32'd1);
    end
    check("churn done count", 32'(done_cnt_a), 32'd4);

    // Asynchronous reset during data bit 3 of 0x55
    a_if.tx_data  = 8'h55;
    a_if.tx_valid = 1'b1;
    @(negedge clk);
    a_if.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid bit3 line", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst line",  32'(tx_a), 32'd1);
    check("mid rst busy",  32'(busy_a), 32'd0);
    check("mid rst ready", 32'(a_if.tx_ready), 32'd1);
    check("mid rst done",  32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid no done",   32'(done_cnt_a), 32'd4);
    check("mid idle line", 32'(tx_a), 32'd1);
    a_if.tx_data  = 8'h0F;
    a_if.tx_valid = 1'b1;
    @(negedge clk);
    frame_a(8'h0F, 0, "post0f");
    @(negedge clk);
    check("post0f done count", 32'(done_cnt_a), 32'd5);

    // One clock per bit, word 0x01
    b_if.tx_data  = 8'h01;
    b_if.tx_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 10; c++) begin
      logic [7:0] w;
      logic       exp_bit;
      w = 8'h01;
      if (c == 0)      exp_bit = 1'b0;
      else if (c <= 8) exp_bit = w[c - 1];
      else             exp_bit = 1'b1;
      check("cpb1 tx_out", 32'(tx_b), 32'(exp_bit));
      check("cpb1 done",   32'(done_b), 32'(c == 10));
      check("cpb1 ready",  32'(b_if.tx_ready), 32'(c == 10));
      b_if.tx_valid = 1'b0;
      if (c < 10) @(negedge clk);
    end
    @(negedge clk);
    check("cpb1 done clear", 32'(done_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
